wb_stage: RTL and testbench



---
 rtl/wb_stage.sv | 152 +++++++++++++++
 tb/tb_wb_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results directly and waits on load data with a timeout.
// Optional macro WB_FWD_EN adds a one-cycle-delayed copy of the write port for ID bypass.
package wb_pkg;
    localparam logic [5:0] OP_LDW  = 6'h23;
    localparam logic [5:0] OP_SDW  = 6'h2b;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_JUMP = 6'h02;
endpackage

module wb_stage
    import wb_pkg::*;
#(
    parameter int LOAD_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  opcode_in,
    input  logic [4:0]  rwd_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic [4:0]  rwd_out,
    output logic [31:0] wb_data,
    output logic        wb_we,
    output logic [31:0] retire_cnt,
    output logic        load_err,
    output logic [31:0] err_pc
`ifdef WB_FWD_EN
    ,
    output logic        fwd_valid,
    output logic [4:0]  fwd_rd,
    output logic [31:0] fwd_data
`endif
);

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } state_t;

    localparam logic [7:0] TMO = 8'(LOAD_TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d, cnt_inc;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] pc_q, pc_d;
    logic        we_d;
    logic [4:0]  rwd_d;
    logic [31:0] data_d;
    logic [31:0] retire_d;
    logic        lerr_d;
    logic [31:0] epc_d;
    logic        accept;

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid & in_ready;
    assign cnt_inc  = cnt_q + 8'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        pc_d     = pc_q;
        we_d     = 1'b0;
        rwd_d    = 5'd0;
        data_d   = wb_data;
        retire_d = retire_cnt;
        lerr_d   = 1'b0;
        epc_d    = err_pc;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (opcode_in == OP_LDW && rwd_in != 5'd0) begin
                        state_d = WAIT_MEM;
                        rd_d    = rwd_in;
                        pc_d    = pc_in;
                        cnt_d   = 8'd0;
                    end else begin
                        retire_d = retire_cnt + 32'd1;
                        if (rwd_in != 5'd0) begin
                            we_d   = 1'b1;
                            rwd_d  = rwd_in;
                            data_d = alu_result_in;
                        end
                    end
                end
            end
            WAIT_MEM: begin
                // Returning data beats a timeout landing in the same cycle
                if (mem_rvalid) begin
                    we_d     = 1'b1;
                    rwd_d    = rd_q;
                    data_d   = mem_rdata;
                    retire_d = retire_cnt + 32'd1;
                    state_d  = IDLE;
                end else if (cnt_inc == TMO) begin
                    lerr_d  = 1'b1;
                    epc_d   = pc_q;
                    cnt_d   = 8'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            rd_q       <= 5'd0;
            pc_q       <= 32'd0;
            wb_we      <= 1'b0;
            rwd_out    <= 5'd0;
            wb_data    <= 32'd0;
            retire_cnt <= 32'd0;
            load_err   <= 1'b0;
            err_pc     <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            pc_q       <= pc_d;
            wb_we      <= we_d;
            rwd_out    <= rwd_d;
            wb_data    <= data_d;
            retire_cnt <= retire_d;
            load_err   <= lerr_d;
            err_pc     <= epc_d;
        end
    end

`ifdef WB_FWD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_valid <= 1'b0;
            fwd_rd    <= 5'd0;
            fwd_data  <= 32'd0;
        end else begin
            fwd_valid <= wb_we;
            fwd_rd    <= rwd_out;
            fwd_data  <= wb_data;
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: write port checked through an expected-write queue,
// status outputs checked inline after each step.
module tb_wb_stage;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  opcode_in;
    logic [4:0]  rwd_in;
    logic [31:0] alu_result_in;
    logic [31:0] pc_in;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic [4:0]  rwd_out;
    logic [31:0] wb_data;
    logic        wb_we;
    logic [31:0] retire_cnt;
    logic        load_err;
    logic [31:0] err_pc;
`ifdef WB_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .opcode_in(opcode_in),
        .rwd_in(rwd_in),
        .alu_result_in(alu_result_in),
        .pc_in(pc_in),
        .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid),
        .rwd_out(rwd_out),
        .wb_data(wb_data),
        .wb_we(wb_we),
        .retire_cnt(retire_cnt),
        .load_err(load_err),
        .err_pc(err_pc)
`ifdef WB_FWD_EN
        ,
        .fwd_valid(fwd_valid),
        .fwd_rd(fwd_rd),
        .fwd_data(fwd_data)
`endif
    );

    task automatic check(input string tag, input logic [36:0] obs,
                         input logic [36:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [5:0] op, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] pc);
        in_valid      = 1'b1;
        opcode_in     = op;
        rwd_in        = rd;
        alu_result_in = alu;
        pc_in         = pc;
    endtask

    // Every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (wb_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {rwd_out, wb_data}, 37'd0);
            end else begin
                check("write_port", {rwd_out, wb_data}, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        opcode_in  = 6'd0;
        rwd_in     = 5'd0;
        alu_result_in = 32'd0;
        pc_in      = 32'd0;
        mem_rdata  = 32'd0;
        mem_rvalid = 1'b0;
        @(negedge clk);
        tick();
        rst = 1'b0;
        check("rst_we", 37'(wb_we), 37'd0);
        check("rst_rd", 37'(rwd_out), 37'd0);
        check("rst_data", 37'(wb_data), 37'd0);
        check("rst_retire", 37'(retire_cnt), 37'd0);
        check("rst_lerr", 37'(load_err), 37'd0);
        check("rst_epc", 37'(err_pc), 37'd0);
        check("rst_ready", 37'(in_ready), 37'd1);

        // ALU op writes next cycle
        issue(6'h00, 5'd5, 32'h1234, 32'h0);
        exp_q.push_back({5'd5, 32'h1234});
        tick();
        in_valid = 1'b0;
        check("add_we", 37'(wb_we), 37'd1);
        check("add_retire", 37'(retire_cnt), 37'd1);

        // Store: no write, data holds, still retires
        issue(OP_SDW, 5'd0, 32'h9999, 32'h4);
        tick();
        in_valid = 1'b0;
        check("sdw_we", 37'(wb_we), 37'd0);
        check("sdw_rd", 37'(rwd_out), 37'd0);
        check("sdw_data_hold", 37'(wb_data), 37'h1234);
        check("sdw_retire", 37'(retire_cnt), 37'd2);

        // Back-to-back accepts
        issue(6'h00, 5'd1, 32'hA0A0_0001, 32'h8);
        exp_q.push_back({5'd1, 32'hA0A0_0001});
        tick();
        issue(6'h00, 5'd2, 32'hB0B0_0002, 32'hC);
        exp_q.push_back({5'd2, 32'hB0B0_0002});
        check("b2b_we1", 37'(wb_we), 37'd1);
        tick();
        in_valid = 1'b0;
        check("b2b_we2", 37'(wb_we), 37'd1);
        tick();
        check("b2b_pulse_end", 37'(wb_we), 37'd0);
        check("b2b_retire", 37'(retire_cnt), 37'd4);

        // Load; rvalid in accept cycle ignored, new in_valid ignored while waiting
        issue(OP_LDW, 5'd7, 32'h0, 32'h100);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_1111;
        tick();
        mem_rvalid = 1'b0;
        issue(6'h00, 5'd9, 32'h5A5A, 32'h104);
        check("ldw_ready0", 37'(in_ready), 37'd0);
        check("ldw_no_early", 37'(wb_we), 37'd0);
        tick();
        check("ldw_wait1", 37'(in_ready), 37'd0);
        tick();
        check("ldw_wait2", 37'(in_ready), 37'd0);
        in_valid   = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        exp_q.push_back({5'd7, 32'hDEAD_BEEF});
        tick();
        mem_rvalid = 1'b0;
        check("ldw_we", 37'(wb_we), 37'd1);
        check("ldw_ready1", 37'(in_ready), 37'd1);
        check("ldw_retire", 37'(retire_cnt), 37'd5);

        // Load timeout
        issue(OP_LDW, 5'd4, 32'h0, 32'h40);
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 255; i++) begin
            if (i == 254) begin
                check("tmo_early_lerr", 37'(load_err), 37'd0);
                check("tmo_early_ready", 37'(in_ready), 37'd0);
            end
            tick();
        end
        check("tmo_lerr", 37'(load_err), 37'd1);
        check("tmo_epc", 37'(err_pc), 37'h40);
        check("tmo_we", 37'(wb_we), 37'd0);
        check("tmo_retire", 37'(retire_cnt), 37'd5);
        check("tmo_ready", 37'(in_ready), 37'd1);
        tick();
        check("tmo_pulse_end", 37'(load_err), 37'd0);
        check("tmo_epc_hold", 37'(err_pc), 37'h40);

        // Data arriving on the timeout cycle wins
        issue(OP_LDW, 5'd6, 32'h0, 32'h60);
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 254; i++) tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        exp_q.push_back({5'd6, 32'hCAFE_F00D});
        tick();
        mem_rvalid = 1'b0;
        check("race_we", 37'(wb_we), 37'd1);
        check("race_lerr", 37'(load_err), 37'd0);
        check("race_retire", 37'(retire_cnt), 37'd6);
        check("race_epc", 37'(err_pc), 37'h40);

        // Reset during wait abandons the load
        issue(OP_LDW, 5'd8, 32'h0, 32'h80);
        tick();
        in_valid = 1'b0;
        tick();
        rst        = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7777_7777;
        tick();
        rst        = 1'b0;
        mem_rvalid = 1'b0;
        check("rstw_we", 37'(wb_we), 37'd0);
        check("rstw_rd", 37'(rwd_out), 37'd0);
        check("rstw_data", 37'(wb_data), 37'd0);
        check("rstw_retire", 37'(retire_cnt), 37'd0);
        check("rstw_lerr", 37'(load_err), 37'd0);
        check("rstw_epc", 37'(err_pc), 37'd0);
        check("rstw_ready", 37'(in_ready), 37'd1);
        tick();
        check("rstw_no_late", 37'(wb_we), 37'd0);

        // Reset beats a same-cycle accept
        rst = 1'b1;
        issue(6'h00, 5'd3, 32'hBAD0, 32'h90);
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rstp_we", 37'(wb_we), 37'd0);
        check("rstp_retire", 37'(retire_cnt), 37'd0);

        // Write rd=3 data=0x55, forwarded copy follows one cycle later
        issue(6'h00, 5'd3, 32'h55, 32'hA0);
        exp_q.push_back({5'd3, 32'h55});
        tick();
        in_valid = 1'b0;
        check("fw_retire", 37'(retire_cnt), 37'd1);
        tick();
`ifdef WB_FWD_EN
        check("fwd_valid", 37'(fwd_valid), 37'd1);
        check("fwd_rd", 37'(fwd_rd), 37'd3);
        check("fwd_data", 37'(fwd_data), 37'h55);
        tick();
        check("fwd_valid_end", 37'(fwd_valid), 37'd0);
`endif
        tick();
        check("sb_drained", 37'(exp_q.size()), 37'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, required completion)");
        $fatal(1, "watchdog");
    end

endmodule
